// File: rtl/branch_gshare_predictor_pkg.sv
// Shared types and helpers for the gshare branch predictor: FSM state,
// saturating counter step and the PC/history hash.
package branch_gshare_predictor_pkg;

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  // Helpers work on the widest supported counter and let callers truncate.
  localparam int MAX_CTR_BITS = 4;

  typedef logic [MAX_CTR_BITS-1:0] ctr_max_t;
  typedef logic [MAX_CTR_BITS:0]   ctr_wide_t;

  function automatic ctr_max_t sat_ctr_next(input ctr_max_t ctr, input logic taken,
                                            input int ctrBits);
    ctr_wide_t maxVal;
    maxVal = ctr_wide_t'((1 << ctrBits) - 1);
    sat_ctr_next = ctr;
    if (taken) begin
      if ({1'b0, ctr} < maxVal) sat_ctr_next = ctr + 1'b1;
    end else if (ctr != '0) begin
      sat_ctr_next = ctr - 1'b1;
    end
  endfunction

  function automatic logic [31:0] gshare_index(input logic [31:0] pc, input logic [31:0] ghr,
                                               input int pcShift);
    gshare_index = (pc >> pcShift) ^ ghr;
  endfunction

endpackage

// File: rtl/branch_gshare_predictor_pht_2r1w.sv
// Pattern history table: counter array with two asynchronous read ports
// (predict, update) and one synchronous write port. Contents are not reset.
module branch_pht_2r1w #(
  parameter int DEPTH    = 2048,
  parameter int CTR_BITS = 2,
  parameter int IDX_W    = $clog2(DEPTH)
) (
  input  logic                i_clk,
  input  logic                i_we,
  input  logic [IDX_W-1:0]    i_wr_idx,
  input  logic [CTR_BITS-1:0] i_wr_data,
  input  logic [IDX_W-1:0]    i_rd0_idx,
  output logic [CTR_BITS-1:0] o_rd0_data,
  input  logic [IDX_W-1:0]    i_rd1_idx,
  output logic [CTR_BITS-1:0] o_rd1_data
);

  logic [CTR_BITS-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_wr_idx] <= i_wr_data;
  end

  assign o_rd0_data = r_mem[i_rd0_idx];
  assign o_rd1_data = r_mem[i_rd1_idx];

endmodule

// File: rtl/branch_gshare_predictor.sv
// Gshare global branch predictor with speculative history and checkpoint repair.
// Optional statistics counters are enabled with `define BRANCH_GSHARE_STATS_EN.
module branch_gshare_predictor
  import branch_gshare_predictor_pkg::*;
#(
  parameter int PHT_SIZE  = 2048,
  parameter int CTR_BITS  = 2,
  parameter int HIST_BITS = 11,
  parameter int PC_SHIFT  = 2,
  parameter int IDX_W     = $clog2(PHT_SIZE)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  output logic                 o_ready,
  input  logic                 i_pred_val,
  input  logic [31:0]          i_pred_pc,
  output logic                 o_pred_taken,
  output logic [IDX_W-1:0]     o_pred_idx,
  output logic [HIST_BITS-1:0] o_pred_hist,
  input  logic                 i_upd_val,
  input  logic [IDX_W-1:0]     i_upd_idx,
  input  logic                 i_upd_taken,
  input  logic                 i_upd_mispred,
  input  logic [HIST_BITS-1:0] i_upd_hist,
  output logic [31:0]          o_stat_updates,
  output logic [31:0]          o_stat_mispreds
);

  localparam logic [CTR_BITS-1:0] WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  state_t               r_state;
  logic [IDX_W-1:0]     r_initPtr;
  logic [HIST_BITS-1:0] r_ghr;
  logic                 r_ready;

  logic                 w_run;
  logic [IDX_W-1:0]     w_predIdx;
  logic [CTR_BITS-1:0]  w_rd0Data;
  logic [CTR_BITS-1:0]  w_rd1Data;
  logic                 w_predTaken;
  logic [CTR_BITS-1:0]  w_updNext;
  logic                 w_we;
  logic [IDX_W-1:0]     w_wrIdx;
  logic [CTR_BITS-1:0]  w_wrData;

  assign w_run       = (r_state == RUN);
  assign w_predIdx   = IDX_W'(gshare_index(i_pred_pc, 32'(r_ghr), PC_SHIFT));
  assign w_predTaken = w_rd0Data[CTR_BITS-1];
  assign w_updNext   = CTR_BITS'(sat_ctr_next(ctr_max_t'(w_rd1Data), i_upd_taken, CTR_BITS));

  // The single write port belongs to the initialiser until the table is ready.
  always_comb begin
    w_we     = 1'b0;
    w_wrIdx  = r_initPtr;
    w_wrData = WNT;
    if (!w_run) begin
      w_we = 1'b1;
    end else if (i_upd_val) begin
      w_we     = 1'b1;
      w_wrIdx  = i_upd_idx;
      w_wrData = w_updNext;
    end
  end

  branch_pht_2r1w #(
    .DEPTH    (PHT_SIZE),
    .CTR_BITS (CTR_BITS),
    .IDX_W    (IDX_W)
  ) u_pht (
    .i_clk      (i_clk),
    .i_we       (w_we),
    .i_wr_idx   (w_wrIdx),
    .i_wr_data  (w_wrData),
    .i_rd0_idx  (w_predIdx),
    .o_rd0_data (w_rd0Data),
    .i_rd1_idx  (i_upd_idx),
    .o_rd1_data (w_rd1Data)
  );

  // Mispredict repair takes priority over a same-cycle speculative shift.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= INIT;
      r_initPtr <= '0;
      r_ghr     <= '0;
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        INIT: begin
          r_initPtr <= r_initPtr + 1'b1;
          if (r_initPtr == IDX_W'(PHT_SIZE - 1)) begin
            r_state <= RUN;
            r_ready <= 1'b1;
          end
        end
        RUN: begin
          if (i_upd_val && i_upd_mispred) begin
            r_ghr <= HIST_BITS'({i_upd_hist, i_upd_taken});
          end else if (i_pred_val) begin
            r_ghr <= HIST_BITS'({r_ghr, w_predTaken});
          end
        end
        default: r_state <= INIT;
      endcase
    end
  end

  assign o_ready      = r_ready;
  assign o_pred_taken = w_run & w_predTaken;
  assign o_pred_idx   = w_run ? w_predIdx : '0;
  assign o_pred_hist  = r_ghr;

`ifdef BRANCH_GSHARE_STATS_EN
  logic [31:0] r_statUpdates;
  logic [31:0] r_statMispreds;

  // Saturating counters of honoured updates and of those flagged mispredicted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_statUpdates  <= '0;
      r_statMispreds <= '0;
    end else if (w_run && i_upd_val) begin
      if (r_statUpdates != '1) r_statUpdates <= r_statUpdates + 1'b1;
      if (i_upd_mispred && (r_statMispreds != '1)) r_statMispreds <= r_statMispreds + 1'b1;
    end
  end

  assign o_stat_updates  = r_statUpdates;
  assign o_stat_mispreds = r_statMispreds;
`else
  assign o_stat_updates  = '0;
  assign o_stat_mispreds = '0;
`endif

endmodule

// File: tb/tb_branch_gshare_predictor.sv
// Self-checking bench for branch_gshare_predictor: directed corner cases,
// a saturation vector table and randomized traffic against a behavioural model.
module tb_branch_gshare_predictor;

  localparam int PHT_SIZE  = 2048;
  localparam int IDX_W     = 11;
  localparam int HIST_BITS = 11;
  localparam int HMASK     = (1 << HIST_BITS) - 1;
  localparam int CTR_MAX   = 3;
  localparam int WNT       = 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 ready;
  logic                 pred_val;
  logic [31:0]          pred_pc;
  logic                 pred_taken;
  logic [IDX_W-1:0]     pred_idx;
  logic [HIST_BITS-1:0] pred_hist;
  logic                 upd_val;
  logic [IDX_W-1:0]     upd_idx;
  logic                 upd_taken;
  logic                 upd_mispred;
  logic [HIST_BITS-1:0] upd_hist;
  logic [31:0]          stat_updates;
  logic [31:0]          stat_mispreds;

  always #5 clk = ~clk;

  branch_gshare_predictor #(
    .PHT_SIZE  (PHT_SIZE),
    .CTR_BITS  (2),
    .HIST_BITS (HIST_BITS),
    .PC_SHIFT  (2)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .o_ready         (ready),
    .i_pred_val      (pred_val),
    .i_pred_pc       (pred_pc),
    .o_pred_taken    (pred_taken),
    .o_pred_idx      (pred_idx),
    .o_pred_hist     (pred_hist),
    .i_upd_val       (upd_val),
    .i_upd_idx       (upd_idx),
    .i_upd_taken     (upd_taken),
    .i_upd_mispred   (upd_mispred),
    .i_upd_hist      (upd_hist),
    .o_stat_updates  (stat_updates),
    .o_stat_mispreds (stat_mispreds)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model: counters as plain integers, history as an integer.
  int mPht [PHT_SIZE];
  int mGhr;
  int mUpdates;
  int mMispreds;

  logic                 obsTaken;
  logic [IDX_W-1:0]     obsIdx;
  logic [HIST_BITS-1:0] obsHist;

  typedef struct {
    logic taken;
    logic expPred;
  } satVec_t;

  satVec_t satTab [7];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic int expStat(input int v);
`ifdef BRANCH_GSHARE_STATS_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic resetModel();
    foreach (mPht[i]) mPht[i] = WNT;
    mGhr      = 0;
    mUpdates  = 0;
    mMispreds = 0;
  endtask

  task automatic driveIdle();
    pred_val    = 1'b0;
    pred_pc     = 32'h0;
    upd_val     = 1'b0;
    upd_idx     = '0;
    upd_taken   = 1'b0;
    upd_mispred = 1'b0;
    upd_hist    = '0;
  endtask

  // One RUN-mode cycle: drive, check combinational outputs mid-cycle, advance model.
  task automatic applyStimulus(input logic pv, input logic [31:0] pc, input logic uv,
                               input logic [IDX_W-1:0] ui, input logic ut, input logic um,
                               input logic [HIST_BITS-1:0] uh);
    int  eIdx;
    int  c;
    bit  eTaken;
    pred_val    = pv;
    pred_pc     = pc;
    upd_val     = uv;
    upd_idx     = ui;
    upd_taken   = ut;
    upd_mispred = um;
    upd_hist    = uh;
    @(negedge clk);
    eIdx   = ((int'(pc >> 2)) & (PHT_SIZE - 1)) ^ mGhr;
    eTaken = (mPht[eIdx] >= 2);
    obsTaken = pred_taken;
    obsIdx   = pred_idx;
    obsHist  = pred_hist;
    checkOutput("pred_idx", 32'(pred_idx), 32'(eIdx));
    checkOutput("pred_taken", 32'(pred_taken), 32'(eTaken));
    checkOutput("pred_hist", 32'(pred_hist), 32'(mGhr));
    checkOutput("ready", 32'(ready), 32'd1);
    checkOutput("stat_updates", stat_updates, 32'(expStat(mUpdates)));
    checkOutput("stat_mispreds", stat_mispreds, 32'(expStat(mMispreds)));
    if (uv) begin
      c = mPht[ui];
      if (ut) c = (c < CTR_MAX) ? c + 1 : c;
      else    c = (c > 0) ? c - 1 : 0;
      mPht[ui] = c;
      mUpdates++;
      if (um) mMispreds++;
    end
    if (uv && um)  mGhr = ((int'(uh) * 2) + int'(ut)) & HMASK;
    else if (pv)   mGhr = ((mGhr * 2) + int'(eTaken)) & HMASK;
    @(posedge clk);
    #1;
  endtask

  // Called right after reset release; ports are deliberately busy to prove they are ignored.
  task automatic waitInit(input string tag);
    int n;
    n = 0;
    pred_val    = 1'b1;
    pred_pc     = $urandom;
    upd_val     = 1'b1;
    upd_idx     = 11'h010;
    upd_taken   = 1'b1;
    upd_mispred = 1'b1;
    upd_hist    = 11'h7FF;
    while (ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      checkOutput({tag, "_init_hist"}, 32'(pred_hist), 32'd0);
      checkOutput({tag, "_init_idx"}, 32'(pred_idx), 32'd0);
      checkOutput({tag, "_init_taken"}, 32'(pred_taken), 32'd0);
      @(posedge clk);
      #1;
      n++;
      pred_pc = $urandom;
    end
    checkOutput({tag, "_init_cycles"}, 32'(n), 32'd2048);
    driveIdle();
  endtask

  task automatic sweepTable();
    for (int i = 0; i < PHT_SIZE; i++) begin
      applyStimulus(1'b0, 32'(i << 2), 1'b0, '0, 1'b0, 1'b0, '0);
    end
  endtask

  initial begin
    logic [4:0] misPat;
    satTab[0] = '{taken: 1'b1, expPred: 1'b1};
    satTab[1] = '{taken: 1'b1, expPred: 1'b1};
    satTab[2] = '{taken: 1'b1, expPred: 1'b1};
    satTab[3] = '{taken: 1'b0, expPred: 1'b1};
    satTab[4] = '{taken: 1'b0, expPred: 1'b0};
    satTab[5] = '{taken: 1'b0, expPred: 1'b0};
    satTab[6] = '{taken: 1'b0, expPred: 1'b0};

    rst_n = 1'b0;
    driveIdle();
    pred_pc = 32'h0000_0ABC;
    #2;
    checkOutput("reset_ready", 32'(ready), 32'd0);
    checkOutput("reset_hist", 32'(pred_hist), 32'd0);
    checkOutput("reset_idx", 32'(pred_idx), 32'd0);
    checkOutput("reset_taken", 32'(pred_taken), 32'd0);
    checkOutput("reset_stat_upd", stat_updates, 32'd0);
    checkOutput("reset_stat_mis", stat_mispreds, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    waitInit("boot");
    resetModel();

    $display("[TB] all entries weakly not-taken");
    sweepTable();

    $display("[TB] same-index predict/update collision");
    applyStimulus(1'b0, 32'h40, 1'b1, 11'h010, 1'b1, 1'b0, '0);
    checkOutput("collision_same", 32'(obsTaken), 32'd0);
    applyStimulus(1'b0, 32'h40, 1'b0, '0, 1'b0, 1'b0, '0);
    checkOutput("collision_next", 32'(obsTaken), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1, 11'h010, 1'b0, 1'b0, '0);

    $display("[TB] counter saturation table");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 32'h40, 1'b1, 11'h010, satTab[i].taken, 1'b0, '0);
      applyStimulus(1'b0, 32'h40, 1'b0, '0, 1'b0, 1'b0, '0);
      checkOutput($sformatf("sat_%0d", i), 32'(obsTaken), 32'(satTab[i].expPred));
    end

    $display("[TB] hash and speculative shift");
    applyStimulus(1'b0, 32'h0, 1'b1, 11'h7FF, 1'b1, 1'b1, 11'h002);
    applyStimulus(1'b1, 32'h0000_0100, 1'b0, '0, 1'b0, 1'b0, '0);
    checkOutput("hash_idx", 32'(obsIdx), 32'h045);
    checkOutput("hash_hist", 32'(obsHist), 32'h005);
    applyStimulus(1'b0, 32'h0, 1'b0, '0, 1'b0, 1'b0, '0);
    checkOutput("hash_shift", 32'(obsHist), 32'h00A);

    $display("[TB] mispredict repair beats speculative shift");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, $urandom, 1'b0, '0, 1'b0, 1'b0, '0);
    end
    applyStimulus(1'b1, $urandom, 1'b1, 11'h200, 1'b1, 1'b1, 11'h123);
    applyStimulus(1'b0, 32'h0, 1'b0, '0, 1'b0, 1'b0, '0);
    checkOutput("repair_hist", 32'(obsHist), 32'h247);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom & 32'h0000_00FC,
                    1'($urandom_range(0, 1)), 11'($urandom_range(0, 63)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                    11'($urandom));
    end

    $display("[TB] reset during RUN");
    applyStimulus(1'b0, 32'h0, 1'b1, 11'h020, 1'b1, 1'b1, 11'h123);
    #3;
    rst_n = 1'b0;
    driveIdle();
    #1;
    checkOutput("midreset_ready", 32'(ready), 32'd0);
    checkOutput("midreset_hist", 32'(pred_hist), 32'd0);
    checkOutput("midreset_stat", stat_updates, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    waitInit("rerun");
    resetModel();
    sweepTable();

    misPat = 5'b01001;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 11'(k + 3), 1'b1, misPat[k], 11'h055);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, '0, 1'b0, 1'b0, '0);
`ifdef BRANCH_GSHARE_STATS_EN
    checkOutput("stats_updates", stat_updates, 32'd5);
    checkOutput("stats_mispreds", stat_mispreds, 32'd2);
`else
    checkOutput("stats_updates", stat_updates, 32'd0);
    checkOutput("stats_mispreds", stat_mispreds, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
